// File: rtl/fmult_seq_nch.sv
`timescale 1ns/1ps
// Sequenced multi-channel G.726 floating-point multiplier: each channel takes 8 cycles
// (LOAD, 6x MUL, STORE). Optional accumulator enabled by defining FMULT_ACCUM_EN.
module fmult_seq_nch #(
  parameter int NCH  = 8,
  parameter int CH_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [16*NCH-1:0]   an_flat,
  input  logic [11*NCH-1:0]   sr_flat,
  output logic                busy,
  output logic                done,
  output logic [16*NCH-1:0]   wa_flat,
  output logic [15:0]         sum
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  // start is a level request sampled only in IDLE (never queued); busy spans the
  // run up to the last STORE and done pulses for the single cycle after it.
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_STORE, S_DONE} state_t;

  state_t          state_q;
  logic [CH_W-1:0] ch_q;
  logic [2:0]      k_q;
  logic            busy_q, done_q;
  logic [15:2]     an_q [NCH];
  logic [10:0]     sr_q [NCH];
  logic [15:0]     wa_q [NCH];
  logic [4:0]      aexp_q, sexp_q, wexp_q;
  logic            carry_q;
  logic [5:0]      amant_q;
  // Bit 0 of the shift-add register is always zero, so only [12:1] (the true product) is kept.
  logic [12:1]     prod_q;

  logic [IW-1:0]   ch_idx;
  logic [15:2]     an_cur;
  logic [10:0]     sr_cur;
  logic [13:0]     an_mag;
  logic [3:0]      an_exp;
  logic [5:0]      an_mant;
  logic [6:0]      pp_sum;
  logic [12:1]     prod_d;
  logic [1:0]      ebit;
  logic [4:0]      wexp_d;
  logic [7:0]      wa_mant;
  logic [14:0]     wa_base, wa_mag;
  logic [15:0]     wa_d;
  logic            accept, store;
  logic [2*NCH-1:0] unused_an_lsbs;

  assign ch_idx = ch_q[IW-1:0];
  assign an_cur = an_q[ch_idx];
  assign sr_cur = sr_q[ch_idx];
  assign accept = (state_q == S_IDLE) && start;
  assign store  = (state_q == S_STORE);

  assign an_mag  = an_cur[15] ? (14'h0 - an_cur[15:2]) : an_cur[15:2];
  assign an_mant = (an_mag == 14'd0) ? 6'h20 : 6'({an_mag, 6'b0} >> an_exp);

  always_comb begin
    an_exp = 4'd0;
    if (an_mag >= 14'd4096) an_exp = 4'd13;
    else begin
      for (int b = 0; b < 12; b++) begin
        if (an_mag[b]) an_exp = 4'(b + 1);
      end
    end
  end

  assign pp_sum = {1'b0, amant_q[0] ? sr_cur[5:0] : 6'd0} + {1'b0, prod_q[12:7]};
  assign prod_d = {pp_sum, prod_q[6:2]};
  assign ebit   = {1'b0, aexp_q[0]} + {1'b0, sexp_q[0]} + {1'b0, carry_q};
  assign wexp_d = {ebit[0], wexp_q[4:1]};

  assign wa_mant = 8'((prod_q[12:1] + 12'd48) >> 4);
  assign wa_base = {wa_mant, 7'b0};
  assign wa_mag  = (wexp_q <= 5'd26) ? (wa_base >> (5'd26 - wexp_q))
                                     : (wa_base << (wexp_q - 5'd26));
  assign wa_d    = (an_cur[15] ^ sr_cur[10]) ? 16'(17'h10000 - {2'b0, wa_mag})
                                             : {1'b0, wa_mag};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      aexp_q  <= '0;
      sexp_q  <= '0;
      wexp_q  <= '0;
      carry_q <= 1'b0;
      amant_q <= '0;
      prod_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        an_q[i] <= '0;
        sr_q[i] <= '0;
        wa_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < NCH; i++) begin
              an_q[i] <= an_flat[16*i+2 +: 14];
              sr_q[i] <= sr_flat[11*i +: 11];
            end
            ch_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          aexp_q  <= {1'b0, an_exp};
          sexp_q  <= {1'b0, sr_cur[9:6]};
          amant_q <= an_mant;
          prod_q  <= '0;
          carry_q <= 1'b0;
          wexp_q  <= '0;
          k_q     <= '0;
          state_q <= S_MUL;
        end
        S_MUL: begin
          prod_q  <= prod_d;
          amant_q <= {1'b0, amant_q[5:1]};
          k_q     <= k_q + 3'd1;
          if (k_q != 3'd5) begin
            wexp_q  <= wexp_d;
            carry_q <= ebit[1];
            aexp_q  <= {1'b0, aexp_q[4:1]};
            sexp_q  <= {1'b0, sexp_q[4:1]};
          end else begin
            state_q <= S_STORE;
          end
        end
        S_STORE: begin
          wa_q[ch_idx] <= wa_d;
          if (ch_q == CH_W'(NCH - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  for (genvar i = 0; i < NCH; i++) begin : g_pack
    assign wa_flat[16*i +: 16]       = wa_q[i];
    assign unused_an_lsbs[2*i +: 2]  = an_flat[16*i +: 2];
  end

`ifdef FMULT_ACCUM_EN
  logic [15:0] sum_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       sum_q <= '0;
    else if (accept) sum_q <= '0;
    else if (store)  sum_q <= sum_q + wa_d;
  end
  assign sum = sum_q;
`else
  logic unused_acc;
  assign unused_acc = accept ^ store;
  assign sum = 16'h0;
`endif

endmodule
